multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute, memory
// and write-back, drives datapath strobes and counts retired instructions.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic [2:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        halted,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        HALT    = 3'd7
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [31:0] TMO = 32'(MEM_TIMEOUT);

    state_t      state_q;
    state_t      state_n;
    logic [31:0] tcnt_q;
    logic [31:0] instret_q;

    logic is_r;
    logic is_i;
    logic is_ld;
    logic is_st;
    logic is_br;
    logic is_lui;
    logic is_auipc;
    logic is_jal;
    logic is_jalr;
    logic legal;
    logic sel_a;
    logic sel_b;
    logic wait_mem;
    logic tmo_hit;

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_ld    = (opcode == OP_LD);
    assign is_st    = (opcode == OP_ST);
    assign is_br    = (opcode == OP_BR);
    assign is_lui   = (opcode == OP_LUI);
    assign is_auipc = (opcode == OP_AUIPC);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);

    assign legal = is_r | is_i | is_ld | is_st | is_br
                 | is_lui | is_auipc | is_jal | is_jalr;

    // ALU operand selects are a pure function of opcode so MEM/WB hold them
    assign sel_a = is_auipc | is_jal | is_br;
    assign sel_b = is_i | is_ld | is_st | is_auipc
                 | is_jal | is_jalr | is_br;

    assign wait_mem = rst_n && !mem_ready
                    && (state_q == FETCH || state_q == MEM);

    assign tmo_hit = (TMO != 32'd0) && wait_mem
                   && (tcnt_q + 32'd1 >= TMO);

    always_comb begin
        state_n      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        rf_we        = 1'b0;
        pc_src       = 2'd0;
        wb_sel       = 2'd0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        halted       = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        state_n = DECODE;
                    end
                end
                DECODE: begin
                    state_n = legal ? EXECUTE : HALT;
                end
                EXECUTE: begin
                    alu_a_sel = sel_a;
                    alu_b_sel = sel_b;
                    unique case (1'b1)
                        is_r, is_i, is_lui,
                        is_auipc, is_jal, is_jalr: state_n = WB;
                        is_ld, is_st: state_n = MEM;
                        is_br: begin
                            pc_we   = 1'b1;
                            pc_src  = branch_taken ? 2'd1 : 2'd0;
                            state_n = FETCH;
                        end
                        default: state_n = HALT;
                    endcase
                end
                MEM: begin
                    alu_a_sel    = sel_a;
                    alu_b_sel    = sel_b;
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = is_st;
                    if (mem_ready) begin
                        if (is_st) begin
                            pc_we   = 1'b1;
                            state_n = FETCH;
                        end else begin
                            state_n = WB;
                        end
                    end
                end
                WB: begin
                    alu_a_sel = sel_a;
                    alu_b_sel = sel_b;
                    rf_we     = 1'b1;
                    pc_we     = 1'b1;
                    state_n   = FETCH;
                    unique case (1'b1)
                        is_ld:          wb_sel = 2'd1;
                        is_jal, is_jalr: wb_sel = 2'd2;
                        is_lui:         wb_sel = 2'd3;
                        default:        wb_sel = 2'd0;
                    endcase
                    if (is_jal) begin
                        pc_src = 2'd1;
                    end else if (is_jalr) begin
                        pc_src = 2'd2;
                    end
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: state_n = HALT;
            endcase
            if (tmo_hit) begin
                state_n = HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            tcnt_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_n;
            if (pc_we) begin
                instret_q <= instret_q + 32'd1;
            end
            if (state_n != state_q || mem_ready) begin
                tcnt_q <= '0;
            end else if (wait_mem) begin
                tcnt_q <= tcnt_q + 32'd1;
            end
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequencing,
// memory stalls, timeout, halt, reset abort and instret wrap.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [2:0]  state;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic        rf_we;
    logic [1:0]  pc_src;
    logic [1:0]  wb_sel;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic        halted;
    logic [31:0] instret;

    int nchk = 0;
    int nerr = 0;
    logic [31:0] exp_ir = 32'd0;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .state        (state),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .pc_src       (pc_src),
        .wb_sel       (wb_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .halted       (halted),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] strobes();
        return {mem_req, mem_we, ir_we, pc_we, rf_we};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_strobes", 32'(strobes()), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("post_rst_req", 32'(mem_req), 32'd1);
        check("post_rst_state", 32'(state), 32'd0);
        exp_ir = 32'd0;
    endtask

    task automatic run_wb(input string tag,
                          input logic [6:0] op,
                          input logic [1:0] ab,
                          input logic [1:0] wb,
                          input logic [1:0] src);
        opcode    = op;
        mem_ready = 1'b1;
        #1;
        check({tag, "_f_state"}, 32'(state), 32'd0);
        check({tag, "_f_irwe"}, 32'(ir_we), 32'd1);
        check({tag, "_f_asel"}, 32'(mem_addr_sel), 32'd0);
        go();
        check({tag, "_d_state"}, 32'(state), 32'd1);
        go();
        check({tag, "_e_state"}, 32'(state), 32'd2);
        check({tag, "_e_alu"}, 32'({alu_a_sel, alu_b_sel}), 32'(ab));
        go();
        check({tag, "_w_state"}, 32'(state), 32'd4);
        check({tag, "_w_we"}, 32'({rf_we, pc_we}), 32'd3);
        check({tag, "_w_wbsel"}, 32'(wb_sel), 32'(wb));
        check({tag, "_w_pcsrc"}, 32'(pc_src), 32'(src));
        check({tag, "_w_alu"}, 32'({alu_a_sel, alu_b_sel}), 32'(ab));
        go();
        exp_ir = exp_ir + 32'd1;
        check({tag, "_ret_state"}, 32'(state), 32'd0);
        check({tag, "_instret"}, instret, exp_ir);
    endtask

    initial begin
        do_reset();

        run_wb("r", 7'b0110011, 2'b00, 2'd0, 2'd0);
        run_wb("i", 7'b0010011, 2'b01, 2'd0, 2'd0);
        run_wb("auipc", 7'b0010111, 2'b11, 2'd0, 2'd0);
        run_wb("lui", 7'b0110111, 2'b00, 2'd3, 2'd0);
        run_wb("jal", 7'b1101111, 2'b11, 2'd2, 2'd1);
        run_wb("jalr", 7'b1100111, 2'b01, 2'd2, 2'd2);

        // load with three stall cycles in MEM: eight cycles total
        opcode    = 7'b0000011;
        mem_ready = 1'b1;
        go();
        go();
        check("ld_e_state", 32'(state), 32'd2);
        mem_ready = 1'b0;
        go();
        check("ld_m_state", 32'(state), 32'd3);
        check("ld_m_req", 32'({mem_req, mem_addr_sel}), 32'd3);
        check("ld_m_we", 32'(mem_we), 32'd0);
        go();
        go();
        go();
        check("ld_m4_state", 32'(state), 32'd3);
        mem_ready = 1'b1;
        #1;
        check("ld_m_alu", 32'({alu_a_sel, alu_b_sel}), 32'd1);
        go();
        check("ld_w_state", 32'(state), 32'd4);
        check("ld_w_wbsel", 32'(wb_sel), 32'd1);
        check("ld_w_rfwe", 32'(rf_we), 32'd1);
        go();
        exp_ir = exp_ir + 32'd1;
        check("ld_ret_state", 32'(state), 32'd0);
        check("ld_instret", instret, exp_ir);

        // taken then not-taken branch
        for (int k = 0; k < 2; k++) begin
            opcode       = 7'b1100011;
            branch_taken = (k == 0);
            go();
            go();
            check("br_e_state", 32'(state), 32'd2);
            check("br_e_pcwe", 32'(pc_we), 32'd1);
            check("br_e_pcsrc", 32'(pc_src), (k == 0) ? 32'd1 : 32'd0);
            check("br_e_alu", 32'({alu_a_sel, alu_b_sel}), 32'd3);
            check("br_e_rfwe", 32'(rf_we), 32'd0);
            go();
            exp_ir = exp_ir + 32'd1;
            check("br_ret_state", 32'(state), 32'd0);
            check("br_instret", instret, exp_ir);
        end
        branch_taken = 1'b0;

        // single-cycle store
        opcode = 7'b0100011;
        go();
        go();
        go();
        check("st_m_state", 32'(state), 32'd3);
        check("st_m_we", 32'({mem_we, mem_addr_sel}), 32'd3);
        check("st_m_pc", 32'({pc_we, pc_src}), 32'b100);
        go();
        exp_ir = exp_ir + 32'd1;
        check("st_ret_state", 32'(state), 32'd0);
        check("st_instret", instret, exp_ir);

        // instret wrap
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        check("wrap_pre", instret, 32'hFFFF_FFFF);
        exp_ir = 32'hFFFF_FFFF;
        run_wb("wrap", 7'b0110011, 2'b00, 2'd0, 2'd0);

        // reset in the middle of a stalled store
        opcode    = 7'b0100011;
        mem_ready = 1'b1;
        go();
        go();
        mem_ready = 1'b0;
        go();
        go();
        check("stx_m_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("stx_we_drop", 32'(mem_we), 32'd0);
        check("stx_state", 32'(state), 32'd0);
        check("stx_instret", instret, 32'd0);
        do_reset();
        mem_ready = 1'b1;
        #1;
        check("stx_refetch", 32'({mem_req, ir_we}), 32'd3);

        // illegal opcode halts
        opcode = 7'b0000000;
        go();
        check("ill_d_state", 32'(state), 32'd1);
        go();
        check("ill_state", 32'(state), 32'd7);
        for (int k = 0; k < 20; k++) begin
            check("ill_halted", 32'(halted), 32'd1);
            check("ill_strobes", 32'(strobes()), 32'd0);
            go();
        end
        check("ill_instret", instret, 32'd0);
        do_reset();

        // fetch timeout
        mem_ready = 1'b0;
        go();
        go();
        go();
        check("tmo_edge3", 32'(state), 32'd0);
        go();
        check("tmo_edge4", 32'(state), 32'd7);
        check("tmo_halted", 32'(halted), 32'd1);
        do_reset();

        // ecall is not legal here
        opcode    = 7'b1110011;
        mem_ready = 1'b1;
        go();
        go();
        check("ecall_halt", 32'(state), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end

endmodule
